// File: rtl/y_ctrl_pkg.sv
// y_ctrl_pkg: shared definitions for the multi-cycle control unit.
//   state_t  - FSM state encoding, visible on the y_ctrl state port
//   kind_t   - instruction class produced by the decoder
//   instr_t  - fields held in the internal instruction register
//   OPC_*    - supported major opcodes
//   ALU_*    - ALU operation codes driven on op
package y_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST_VEC = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    K_ILL  = 3'd0,
    K_R    = 3'd1,
    K_ADDI = 3'd2,
    K_LW   = 3'd3,
    K_SW   = 3'd4,
    K_BEQ  = 3'd5,
    K_JAL  = 3'd6
  } kind_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f30;
  } instr_t;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

endpackage

// File: rtl/y_ctrl_dec.sv
// y_ctrl_dec: purely combinational opcode/funct decoder.
//   instr  in  latched instruction fields
//   kind   out instruction class (K_ILL for anything unsupported)
//   alu_op out ALU operation for that instruction
module y_ctrl_dec
  import y_ctrl_pkg::*;
(
  input  instr_t      instr,
  output kind_t       kind,
  output logic [2:0]  alu_op
);

  // NOTE: every output gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    kind   = K_ILL;
    alu_op = ALU_AND;
    case (instr.opcode)
      OPC_R: begin
        kind = K_R;
        case (instr.funct3)
          3'b000:  alu_op = instr.f30 ? ALU_SUB : ALU_ADD;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          3'b010:  alu_op = ALU_SLT;
          default: kind   = K_ILL;
        endcase
      end
      OPC_ADDI: begin kind = K_ADDI; alu_op = ALU_ADD; end
      OPC_LW:   begin kind = K_LW;   alu_op = ALU_ADD; end
      OPC_SW:   begin kind = K_SW;   alu_op = ALU_ADD; end
      OPC_BEQ:  begin kind = K_BEQ;  alu_op = ALU_SUB; end
      OPC_JAL:  kind = K_JAL;
      default:  ;
    endcase
  end

endmodule

// File: rtl/y_ctrl.sv
// y_ctrl: multi-cycle control FSM with instruction latch and retired count.
//   clk, rst_n  clock, asynchronous active-low reset
//   ins         instruction word, sampled in FETCH
//   zero        ALU zero flag (consumed by the external PC mux with isbranch)
//   intReq      level interrupt request, sampled in commit states
//   RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, isbranch, isjump, op
//               datapath controls
//   pcWrite     PC enable, one pulse per instruction
//   intSel      PC mux selects the entry point
//   illegal     high in TRAP
//   state       current FSM state encoding
//   instret     retired-instruction counter
module y_ctrl
  import y_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        intReq,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic        isbranch,
  output logic        isjump,
  output logic [2:0]  op,
  output logic        pcWrite,
  output logic        intSel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      state_q;
  instr_t      instr_q;
  logic [31:0] instret_q;
  kind_t       kind;
  logic [2:0]  alu_op;
  logic        commit;

  // Only opcode, funct3 and bit 30 matter here; zero is used by the PC mux
  // outside this block together with isbranch.
  logic unused_bits;
  assign unused_bits = ^{ins[31], ins[29:15], ins[11:7], zero};

  y_ctrl_dec u_dec (
    .instr  (instr_q),
    .kind   (kind),
    .alu_op (alu_op)
  );

  // Commit state: last state of each legal instruction's sequence.
  always_comb begin
    commit = 1'b0;
    case (state_q)
      S_EXEC:  commit = (kind == K_BEQ);
      S_MEM:   commit = (kind == K_SW);
      S_WB:    commit = 1'b1;
      default: commit = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST_VEC;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q == S_FETCH)
        instr_q <= '{opcode: ins[6:0], funct3: ins[14:12], f30: ins[30]};
      if (commit)
        instret_q <= instret_q + 32'd1;
      case (state_q)
        S_RST_VEC: state_q <= S_FETCH;
        S_FETCH:   state_q <= S_DECODE;
        S_DECODE: begin
          if (kind == K_ILL)      state_q <= S_TRAP;
          else if (kind == K_JAL) state_q <= S_WB;
          else                    state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (kind == K_BEQ)                      state_q <= S_FETCH;
          else if (kind == K_LW || kind == K_SW)  state_q <= S_MEM;
          else                                    state_q <= S_WB;
        end
        S_MEM:   state_q <= (kind == K_LW) ? S_WB : S_FETCH;
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_FETCH;
        default: state_q <= S_RST_VEC;
      endcase
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

  // Controls decode from the registered state and latch only. They are also
  // gated by rst_n so that asserting reset kills any pulse immediately,
  // without waiting for the flops to settle into RST_VEC.
  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    isbranch = 1'b0;
    isjump   = 1'b0;
    op       = ALU_AND;
    pcWrite  = 1'b0;
    intSel   = 1'b0;
    illegal  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_RST_VEC: begin
          pcWrite = 1'b1;
          intSel  = 1'b1;
        end
        S_TRAP: begin
          pcWrite = 1'b1;
          intSel  = 1'b1;
          illegal = 1'b1;
        end
        S_DECODE, S_EXEC, S_MEM, S_WB: begin
          if (kind != K_ILL) op = alu_op;
          ALUSrc   = (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW);
          RegWrite = (state_q == S_WB);
          MemWrite = (state_q == S_MEM) && (kind == K_SW);
          MemRead  = ((state_q == S_MEM) || (state_q == S_WB)) && (kind == K_LW);
          Mem2Reg  = ((state_q == S_MEM) || (state_q == S_WB)) && (kind == K_LW);
          isbranch = (state_q == S_EXEC) && (kind == K_BEQ);
          isjump   = (state_q == S_WB) && (kind == K_JAL);
          pcWrite  = commit;
          intSel   = commit && intReq;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y_ctrl.sv
// tb_y_ctrl: directed self-checking bench for y_ctrl. Each cycle the full
// control vector is compared against a hand-written table entry.
// Vector layout: {RegWrite,ALUSrc,MemRead,MemWrite,Mem2Reg,isbranch,isjump,
//                 pcWrite,intSel,illegal,op[2:0],state[2:0]}
module tb_y_ctrl;

  logic        clk, rst_n, zero, intReq;
  logic [31:0] ins;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, isbranch, isjump;
  logic [2:0]  op, state;
  logic        pcWrite, intSel, illegal;
  logic [31:0] instret;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_instret = 32'd0;

  y_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .intReq(intReq),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .isbranch(isbranch),
    .isjump(isjump), .op(op), .pcWrite(pcWrite), .intSel(intSel),
    .illegal(illegal), .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, isbranch, isjump,
            pcWrite, intSel, illegal, op, state};
  endfunction

  // Builds an expected vector: rw as mr mw m2r br jp pw is il op st
  function automatic logic [15:0] e(input logic rw, as, mr, mw, m2r, br, jp,
                                    pw, is, il, input logic [2:0] o, st);
    return {rw, as, mr, mw, m2r, br, jp, pw, is, il, o, st};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs() !== 16'h0000) begin
      failed++;
      $display("FAIL reset_ctrl: got %h expected %h", obs(), 16'h0000);
    end
    tests++;
    if (instret !== 32'd0) begin
      failed++;
      $display("FAIL reset_instret: got %h expected %h", instret, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (obs() !== e(0,0,0,0,0,0,0,1,1,0,3'd0,3'd0)) begin
      failed++;
      $display("FAIL rst_vec: got %h expected %h", obs(), e(0,0,0,0,0,0,0,1,1,0,3'd0,3'd0));
    end
    step();
    tests++;
    if (obs() !== e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1)) begin
      failed++;
      $display("FAIL rst_to_fetch: got %h expected %h", obs(), e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1));
    end
  endtask

  task automatic test_addi();
    logic [15:0] ex[$];
    ins = 32'h0050_0093;
    ex = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,1,0,0,0,0,0,0,0,0,3'd2,3'd2),
           e(0,1,0,0,0,0,0,0,0,0,3'd2,3'd3), e(1,1,0,0,0,0,0,1,0,0,3'd2,3'd5)};
    foreach (ex[i]) begin
      tests++;
      if (obs() !== ex[i]) begin
        failed++;
        $display("FAIL addi cyc%0d: got %h expected %h", i, obs(), ex[i]);
      end
      step();
    end
    exp_instret = 32'd1;
    tests++;
    if (instret !== exp_instret || state !== 3'd1) begin
      failed++;
      $display("FAIL addi_instret: got %h/st%0d expected %h/st1", instret, state, exp_instret);
    end
  endtask

  task automatic test_lw_sw();
    logic [15:0] ex_lw[$];
    logic [15:0] ex_sw[$];
    ins = 32'h0000_2283;
    ex_lw = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,1,0,0,0,0,0,0,0,0,3'd2,3'd2),
              e(0,1,0,0,0,0,0,0,0,0,3'd2,3'd3), e(0,1,1,0,1,0,0,0,0,0,3'd2,3'd4),
              e(1,1,1,0,1,0,0,1,0,0,3'd2,3'd5)};
    foreach (ex_lw[i]) begin
      tests++;
      if (obs() !== ex_lw[i]) begin
        failed++;
        $display("FAIL lw cyc%0d: got %h expected %h", i, obs(), ex_lw[i]);
      end
      step();
    end
    ins = 32'h0050_2223;
    ex_sw = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,1,0,0,0,0,0,0,0,0,3'd2,3'd2),
              e(0,1,0,0,0,0,0,0,0,0,3'd2,3'd3), e(0,1,0,1,0,0,0,1,0,0,3'd2,3'd4)};
    foreach (ex_sw[i]) begin
      tests++;
      if (obs() !== ex_sw[i]) begin
        failed++;
        $display("FAIL sw cyc%0d: got %h expected %h", i, obs(), ex_sw[i]);
      end
      step();
    end
    exp_instret = 32'd3;
    tests++;
    if (instret !== exp_instret || state !== 3'd1) begin
      failed++;
      $display("FAIL lw_sw_instret: got %h/st%0d expected %h/st1", instret, state, exp_instret);
    end
  endtask

  task automatic test_beq();
    logic [15:0] ex[$];
    ins = 32'h0000_0463;
    ex = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,0,0,0,0,0,0,0,0,0,3'd6,3'd2),
           e(0,0,0,0,0,1,0,1,0,0,3'd6,3'd3)};
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      foreach (ex[i]) begin
        tests++;
        if (obs() !== ex[i]) begin
          failed++;
          $display("FAIL beq z%0d cyc%0d: got %h expected %h", z, i, obs(), ex[i]);
        end
        step();
      end
    end
    zero = 1'b0;
    exp_instret = 32'd5;
    tests++;
    if (instret !== exp_instret || state !== 3'd1) begin
      failed++;
      $display("FAIL beq_instret: got %h/st%0d expected %h/st1", instret, state, exp_instret);
    end
  endtask

  task automatic test_jal_int();
    logic [15:0] ex[$];
    ins    = 32'h0000_00EF;
    intReq = 1'b1;
    ex = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd2),
           e(1,0,0,0,0,0,1,1,1,0,3'd0,3'd5)};
    foreach (ex[i]) begin
      tests++;
      if (obs() !== ex[i]) begin
        failed++;
        $display("FAIL jal_int cyc%0d: got %h expected %h", i, obs(), ex[i]);
      end
      step();
    end
    intReq = 1'b0;
    exp_instret = 32'd6;
    tests++;
    if (instret !== exp_instret || state !== 3'd1) begin
      failed++;
      $display("FAIL jal_instret: got %h/st%0d expected %h/st1", instret, state, exp_instret);
    end
  endtask

  task automatic test_trap();
    logic [15:0] ex[$];
    ins = 32'hFFFF_FFFF;
    ex = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd2),
           e(0,0,0,0,0,0,0,1,1,1,3'd0,3'd6)};
    foreach (ex[i]) begin
      tests++;
      if (obs() !== ex[i]) begin
        failed++;
        $display("FAIL trap cyc%0d: got %h expected %h", i, obs(), ex[i]);
      end
      step();
    end
    tests++;
    if (instret !== exp_instret || state !== 3'd1) begin
      failed++;
      $display("FAIL trap_instret: got %h/st%0d expected %h/st1", instret, state, exp_instret);
    end
  endtask

  task automatic test_rtype_ops();
    logic [31:0] iw[5]  = '{32'h0020_81B3, 32'h4020_81B3, 32'h0020_E1B3,
                            32'h0020_F1B3, 32'h0020_A1B3};
    logic [2:0]  opx[5] = '{3'b010, 3'b110, 3'b001, 3'b000, 3'b011};
    logic [15:0] ex[$];
    logic [15:0] ex_bad[$];
    for (int k = 0; k < 5; k++) begin
      ins = iw[k];
      ex = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,0,0,0,0,0,0,0,0,0,opx[k],3'd2),
             e(0,0,0,0,0,0,0,0,0,0,opx[k],3'd3), e(1,0,0,0,0,0,0,1,0,0,opx[k],3'd5)};
      foreach (ex[i]) begin
        tests++;
        if (obs() !== ex[i]) begin
          failed++;
          $display("FAIL rtype %h cyc%0d: got %h expected %h", iw[k], i, obs(), ex[i]);
        end
        step();
      end
      exp_instret = exp_instret + 32'd1;
    end
    // R-type with funct3 101 has no decode and goes to TRAP.
    ins = 32'h0020_D1B3;
    ex_bad = '{e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1), e(0,0,0,0,0,0,0,0,0,0,3'd0,3'd2),
               e(0,0,0,0,0,0,0,1,1,1,3'd0,3'd6)};
    foreach (ex_bad[i]) begin
      tests++;
      if (obs() !== ex_bad[i]) begin
        failed++;
        $display("FAIL rtype_bad cyc%0d: got %h expected %h", i, obs(), ex_bad[i]);
      end
      step();
    end
    tests++;
    if (instret !== exp_instret || state !== 3'd1) begin
      failed++;
      $display("FAIL rtype_instret: got %h/st%0d expected %h/st1", instret, state, exp_instret);
    end
  endtask

  task automatic test_instret_wrap();
    dut.instret_q = 32'hFFFF_FFFF;
    ins = 32'h0020_81B3;
    repeat (4) step();
    tests++;
    if (instret !== 32'd0 || state !== 3'd1) begin
      failed++;
      $display("FAIL instret_wrap: got %h/st%0d expected 00000000/st1", instret, state);
    end
  endtask

  task automatic test_reset_abort();
    ins = 32'h0050_2223;
    repeat (3) step();
    tests++;
    if (MemWrite !== 1'b1 || state !== 3'd4) begin
      failed++;
      $display("FAIL abort_pre: got mw%b/st%0d expected mw1/st4", MemWrite, state);
    end
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (obs() !== 16'h0000 || instret !== 32'd0) begin
        failed++;
        $display("FAIL abort_reset cyc%0d: got %h/%h expected 0000/00000000", c, obs(), instret);
      end
      step();
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if (state !== 3'd1) begin
      failed++;
      $display("FAIL abort_restart: got st%0d expected st1", state);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ins    = 32'd0;
    zero   = 1'b0;
    intReq = 1'b0;
    test_reset();
    test_addi();
    test_lw_sw();
    test_beq();
    test_jal_int();
    test_trap();
    test_rtype_ops();
    test_instret_wrap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/y_ctrl.md
Y_CTRL -- requirements
Module: y_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: ins  in  32  instruction word from instruction memory, valid during FETCH.
REQ-004 SHALL provide: zero  in  1  ALU zero flag from execute stage.
REQ-005 SHALL provide: intReq  in  1  level interrupt request.
REQ-006 SHALL provide outputs, 1 bit each unless stated:
- RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, isbranch, isjump
- op (3): ALU op
- pcWrite: PC register enable
- intSel: PC mux selects entryPoint
- illegal
- state (3)
- instret (32): retired-instruction count

Function
REQ-007 SHALL implement states RST_VEC, FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-008 In FETCH, SHALL latch ins[6:0], ins[14:12] and ins[30] into an internal instruction register; later states SHALL decode only from this latch.
REQ-009 SHALL use the following state sequences; the last listed state is the commit state:
- R-type (0x33), addi (0x13): FETCH-DECODE-EXEC-WB (4 cycles)
- lw (0x03): FETCH-DECODE-EXEC-MEM-WB (5)
- sw (0x23): FETCH-DECODE-EXEC-MEM (4)
- beq (0x63): FETCH-DECODE-EXEC (3)
- jal (0x6F): FETCH-DECODE-WB (3)
- any other opcode: DECODE-TRAP
REQ-010 SHALL assert pcWrite for exactly one cycle per instruction, in its commit state; pcWrite SHALL be 0 in all other states.
REQ-011 SHALL assert RegWrite only in WB; MemWrite only in MEM for sw; MemRead and Mem2Reg in MEM and WB for lw.
REQ-012 SHALL hold ALUSrc=1 from DECODE through the commit state for addi, lw and sw; ALUSrc SHALL be 0 otherwise.
REQ-013 SHALL drive op as follows:
- R-type: funct3 000 -> 010 (add), or 110 (sub when ins[30]=1); 110 -> 001 (or); 111 -> 000 (and); 010 -> 011 (slt)
- addi, lw, sw: 010
- beq: 110
- undecoded R-type funct3: illegal, go to TRAP
REQ-014 SHALL assert isbranch in the beq commit state; the PC then takes the branch iff zero=1 in that cycle.
REQ-015 SHALL assert isjump in the jal commit state.
REQ-016 SHALL sample intReq in each commit state; if 1, intSel=1 in that same cycle, so the PC loads entryPoint instead of the computed next PC.
REQ-017 In TRAP (1 cycle), SHALL assert illegal=1, intSel=1 and pcWrite=1, then go to FETCH; RegWrite and MemWrite SHALL be 0.
REQ-018 SHALL increment instret by 1 (mod 2^32) on each non-TRAP commit; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 SHALL make state equal the current state encoding.
REQ-020 SHALL drive all control outputs combinationally from the state and the latched fields; outputs SHALL be glitch-free relative to clk edges.

Reset
REQ-021 While rst_n=0, SHALL force state=RST_VEC, instret=0, instruction latch=0 and all control outputs 0, regardless of clk.
REQ-022 In RST_VEC (1 cycle after deassertion), SHALL assert intSel=1 and pcWrite=1, then go to FETCH.
REQ-023 Reset asserted mid-instruction SHALL abort it with no RegWrite or MemWrite pulse after assertion.

Structure
REQ-024 Package y_ctrl_pkg SHALL hold the state encoding, opcode constants (0x33, 0x13, 0x03, 0x23, 0x63, 0x6F) and ALU op constants.
REQ-025 Opcode/funct decode SHALL be a combinational sub-module y_ctrl_dec; y_ctrl SHALL contain the FSM, latch and counter.

Verification
REQ-026 Reset release, then ins=0x00500093 (addi) -> RST_VEC(pcWrite, intSel); then FETCH, DECODE, EXEC, WB with ALUSrc=1, op=010, RegWrite=1 and pcWrite=1 only in WB; instret=1.
REQ-027 ins=0x00002283 (lw) then 0x00502223 (sw) -> lw takes 5 cycles with MemRead and Mem2Reg in MEM and WB; sw takes 4 cycles with a single MemWrite in MEM and RegWrite=0 throughout.
REQ-028 ins=0x00000463 (beq) with zero=1, then zero=0 -> 3 cycles each, isbranch=1 and op=110 in EXEC, no RegWrite.
REQ-029 ins=0x000000EF (jal) with intReq=1 during WB -> 3 cycles; isjump=1, RegWrite=1, intSel=1 and pcWrite=1 together in WB.
REQ-030 ins=0xFFFFFFFF -> DECODE then TRAP with illegal=1, intSel=1, pcWrite=1; instret unchanged.
REQ-031 Preload instret=0xFFFFFFFF and commit an add (0x002081B3) -> instret=0; assert rst_n=0 in MEM of a sw -> no MemWrite, state=RST_VEC immediately.
